ensemble_vote_combiner: RTL
===========================

# ensemble_vote_combiner

Receives the three per-classifier AXI-Stream result streams (SVM/gradient-boost, logistic regression, MLP) leaving the ensemble wrapper and reduces each aligned triple of predictions to a single majority-vote class label on one AXI-Stream master. It sits directly downstream of the ensemble wrapper's three `m_axis_*` ports and is the consumer end of those streams. It buffers one beat per classifier, so the three cores may finish in any order and at any skew.

## Interface
Parameters:
- `DATA_WIDTH`, 32: tdata width, inputs and output.
- `KEEP_WIDTH`, 4: tkeep width, `DATA_WIDTH/8`.
- `CLASS_WIDTH`, 8: class label width, taken from `tdata[CLASS_WIDTH-1:0]`. Must be ≤ `DATA_WIDTH-2`.
- `TIE_SEL`, 2: index (0..2) of the classifier whose label wins a three-way disagreement.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `s_axis_tdata_i` / `s_axis_tkeep_i` / `s_axis_tvalid_i` / `s_axis_tready_i` / `s_axis_tlast_i`, for i = 0, 1, 2:
  - in / in / in / out / in.
  - Widths `DATA_WIDTH` / `KEEP_WIDTH` / 1 / 1 / 1.
  - Result stream from classifier i.
- `m_axis_tdata`, out, `DATA_WIDTH`: voted result.
- `m_axis_tkeep`, out, `KEEP_WIDTH`: always all ones.
- `m_axis_tvalid`, out, 1: result valid.
- `m_axis_tready`, in, 1: downstream ready.
- `m_axis_tlast`, out, 1: AND of the three held tlasts.
- `last_err`, out, 1: sticky flag, set when a triple's tlasts disagree.

## Operation
- Per input i there is a holding register `hold_i` (data, tlast) and a flag `full_i`.
- `s_axis_tready_i = (state==COLLECT) & ~full_i`. A beat is accepted on `tvalid & tready`; it loads `hold_i` and sets `full_i`.
- The input tkeep is ignored. Bits of tdata above `CLASS_WIDTH` are ignored.
- State machine:
  - **COLLECT**: accept beats. When all three `full_i` would be set at the end of this cycle, including beats accepted this cycle, compute the vote, register the output, and go to EMIT.
  - **EMIT**: hold `m_axis_tvalid=1`. On `m_axis_tready`, clear all `full_i` and return to COLLECT. All input treadys are 0 while in EMIT.
- Vote, with labels a, b, c:
  - a==b==c → label a, count 3.
  - Exactly one pair equal → label of that pair, count 2.
  - All distinct → label of classifier `TIE_SEL`, count 1.
- Output encoding:
  - `tdata[CLASS_WIDTH-1:0]` = label.
  - `tdata[CLASS_WIDTH+1:CLASS_WIDTH]` = count.
  - Remaining bits 0.
- `m_axis_tlast` = `tlast_0 & tlast_1 & tlast_2` of the held beats.
- If the three held tlasts are not all equal, `last_err` sets at the cycle the vote registers. It clears only on reset.
- Output tdata, tlast and tkeep are stable while `m_axis_tvalid=1` and `m_axis_tready=0`.

## Timing
- Reset values:
  - State COLLECT.
  - `full_i=0`, so every `s_axis_tready_i=1`.
  - `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tlast=0`.
  - `m_axis_tkeep` all ones.
  - `last_err=0`.
- Latency: `m_axis_tvalid` rises on the cycle after the third beat is accepted.
- If all three beats arrive in the same cycle, `m_axis_tvalid` rises on the next cycle.
- Throughput: at most one result per 2 cycles (1 accept cycle + 1 emit cycle with tready held high).
- Skew: a classifier that is already full keeps tready low. Its next beat back-pressures until the current result is emitted. Unbounded skew is tolerated.
- Reset asserted mid-operation discards held beats and any pending output on the next edge. No partial result is emitted.
- tvalid is never dropped without a handshake.

## Configuration
- `ENSEMBLE_VOTE_STATS_EN`:
  - Defined: adds three output ports.
    - `stat_total` (out, 32): results emitted.
    - `stat_split` (out, 32): results with count<3.
    - `stat_tie` (out, 32): results with count==1.
  - Each counter increments on the output handshake, wraps at 2^32, and resets to 0.
  - Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Labels 5, 5, 5 presented in the same cycle with `m_axis_tready=1` → next cycle `tdata=0x0000_0305`, tvalid high for 1 cycle, input treadys return to 1 on the following cycle.
- Labels 3, 7, 7 arriving on cycles 0, 4, 9 → tvalid on cycle 10, `tdata=0x0000_0207`. Input 0 tready stays 1 until its beat, then 0.
- Labels 1, 2, 4 with `TIE_SEL=2` → `tdata=0x0000_0104`. Rerun with `TIE_SEL=0` → `tdata=0x0000_0101`.
- `m_axis_tready=0` for 6 cycles after the result is valid → tvalid and tdata stable, all input treadys 0. A second beat on input 1 is held off until the handshake.
- tlast=1, 1, 0 → `m_axis_tlast=0`, `last_err=1`, and it stays 1 through subsequent good triples until `rst`.
- `rst` asserted after two of three beats are held → next cycle all treadys 1, tvalid 0. A fresh triple 9, 9, 2 then yields `tdata=0x0000_0209`.
- With `ENSEMBLE_VOTE_STATS_EN` defined, running the three vote cases above gives `stat_total=3`, `stat_split=2`, `stat_tie=1`.

Source files
------------

// File: rtl/ensemble_vote_combiner.sv
// Majority-vote combiner for three classifier AXI-Stream result streams.
// Optional feature macro: ENSEMBLE_VOTE_STATS_EN adds stat_total/stat_split/stat_tie counters.
module ensemble_vote_combiner #(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = 4,
    parameter int CLASS_WIDTH = 8,
    parameter int TIE_SEL     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
    input  logic                  s_axis_tvalid_0,
    output logic                  s_axis_tready_0,
    input  logic                  s_axis_tlast_0,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
    input  logic                  s_axis_tvalid_1,
    output logic                  s_axis_tready_1,
    input  logic                  s_axis_tlast_1,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
    input  logic                  s_axis_tvalid_2,
    output logic                  s_axis_tready_2,
    input  logic                  s_axis_tlast_2,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  last_err
`ifdef ENSEMBLE_VOTE_STATS_EN
    ,
    output logic [31:0]           stat_total,
    output logic [31:0]           stat_split,
    output logic [31:0]           stat_tie
`endif
);

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t                  state_q;
    logic [2:0]              full_q;
    logic [CLASS_WIDTH-1:0]  hold_lab_q [3];
    logic [2:0]              hold_last_q;
    logic [DATA_WIDTH-1:0]   m_tdata_q;
    logic                    m_tvalid_q;
    logic                    m_tlast_q;
    logic                    last_err_q;

    logic [CLASS_WIDTH-1:0]  in_lab [3];
    logic [2:0]              in_vld;
    logic [2:0]              in_last;
    logic [2:0]              ready_w;
    logic [2:0]              acc;
    logic [CLASS_WIDTH-1:0]  lab_d [3];
    logic [2:0]              last_d;
    logic                    all_full;
    logic [DATA_WIDTH-1:0]   tdata_d;

    // Returns {count, label}; a three-way split falls back to classifier TIE_SEL.
    function automatic logic [CLASS_WIDTH+1:0] vote(
        input logic [CLASS_WIDTH-1:0] a,
        input logic [CLASS_WIDTH-1:0] b,
        input logic [CLASS_WIDTH-1:0] c
    );
        logic [CLASS_WIDTH-1:0] t;
        case (TIE_SEL)
            0:       t = a;
            1:       t = b;
            default: t = c;
        endcase
        if (a == b && b == c)  return {2'd3, a};
        else if (a == b)       return {2'd2, a};
        else if (a == c)       return {2'd2, a};
        else if (b == c)       return {2'd2, b};
        else                   return {2'd1, t};
    endfunction

    assign in_lab[0] = s_axis_tdata_0[CLASS_WIDTH-1:0];
    assign in_lab[1] = s_axis_tdata_1[CLASS_WIDTH-1:0];
    assign in_lab[2] = s_axis_tdata_2[CLASS_WIDTH-1:0];
    assign in_vld    = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
    assign in_last   = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};

    assign ready_w         = {3{state_q == COLLECT}} & ~full_q;
    assign s_axis_tready_0 = ready_w[0];
    assign s_axis_tready_1 = ready_w[1];
    assign s_axis_tready_2 = ready_w[2];

    logic unused_inputs;
    assign unused_inputs = ^{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
                             s_axis_tdata_0[DATA_WIDTH-1:CLASS_WIDTH],
                             s_axis_tdata_1[DATA_WIDTH-1:CLASS_WIDTH],
                             s_axis_tdata_2[DATA_WIDTH-1:CLASS_WIDTH]};

    // Vote sees this cycle's accepted beats merged with previously held ones.
    always_comb begin
        acc      = in_vld & ready_w;
        all_full = &(full_q | acc);
        for (int i = 0; i < 3; i++) begin
            lab_d[i]  = acc[i] ? in_lab[i]  : hold_lab_q[i];
            last_d[i] = acc[i] ? in_last[i] : hold_last_q[i];
        end
        tdata_d = '0;
        tdata_d[CLASS_WIDTH+1:0] = vote(lab_d[0], lab_d[1], lab_d[2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            full_q     <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            last_err_q <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    for (int i = 0; i < 3; i++) begin
                        if (acc[i]) begin
                            hold_lab_q[i]  <= in_lab[i];
                            hold_last_q[i] <= in_last[i];
                            full_q[i]      <= 1'b1;
                        end
                    end
                    if (all_full) begin
                        m_tdata_q  <= tdata_d;
                        m_tlast_q  <= &last_d;
                        m_tvalid_q <= 1'b1;
                        if (!(&last_d) && (|last_d))
                            last_err_q <= 1'b1;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (m_axis_tready) begin
                        full_q     <= '0;
                        m_tvalid_q <= 1'b0;
                        state_q    <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = '1;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign last_err      = last_err_q;

`ifdef ENSEMBLE_VOTE_STATS_EN
    logic [31:0] stat_total_q, stat_split_q, stat_tie_q;
    logic [1:0]  out_count;

    assign out_count = m_tdata_q[CLASS_WIDTH+1:CLASS_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_total_q <= '0;
            stat_split_q <= '0;
            stat_tie_q   <= '0;
        end else if (m_tvalid_q && m_axis_tready) begin
            stat_total_q <= stat_total_q + 32'd1;
            if (out_count != 2'd3) stat_split_q <= stat_split_q + 32'd1;
            if (out_count == 2'd1) stat_tie_q   <= stat_tie_q + 32'd1;
        end
    end

    assign stat_total = stat_total_q;
    assign stat_split = stat_split_q;
    assign stat_tie   = stat_tie_q;
`endif

endmodule
